// File: rtl/qracc_pkg.sv
// Shared types for the activation-buffer arbiter: read-response requester tag
// and the default ext starvation threshold.
package qracc_pkg;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_FL   = 2'd1,
      TAG_EXT  = 2'd2
   } req_tag_t;

   localparam int unsigned STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/qracc_actbuf_arbiter.sv
// Single-port activation buffer arbiter: writeback > feature loader > bus side,
// with starvation promotion of the bus side. Optional stats: QRACC_ACTBUF_ARB_STATS_EN.
module qracc_actbuf_arbiter
   import qracc_pkg::*;
#(
   parameter int unsigned dataWidth   = 32,
   parameter int unsigned addrWidth   = 16,
   parameter int unsigned starveLimit = STARVE_LIMIT_DEF
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 clear_i,
   input  logic                 wb_valid_i,
   output logic                 wb_ready_o,
   input  logic [addrWidth-1:0] wb_addr_i,
   input  logic [dataWidth-1:0] wb_data_i,
   input  logic                 fl_valid_i,
   output logic                 fl_ready_o,
   input  logic [addrWidth-1:0] fl_addr_i,
   output logic                 fl_rsp_valid_o,
   input  logic                 ext_valid_i,
   output logic                 ext_ready_o,
   input  logic                 ext_wen_i,
   input  logic [addrWidth-1:0] ext_addr_i,
   input  logic [dataWidth-1:0] ext_wdata_i,
   output logic                 ext_rsp_valid_o,
   output logic [dataWidth-1:0] rsp_data_o,
   output logic                 mem_en_o,
   output logic                 mem_wen_o,
   output logic [addrWidth-1:0] mem_addr_o,
   output logic [dataWidth-1:0] mem_wdata_o,
   input  logic [dataWidth-1:0] mem_rdata_i,
   output logic [31:0]          stat_conflict_o
);

   localparam int unsigned SW = $clog2(starveLimit) + 1;

   logic [SW-1:0] starve_cnt;
   logic          promoted;
   logic          gnt_wb, gnt_fl, gnt_ext;
   req_tag_t      tag_q, tag_d;

   assign promoted = (starve_cnt == SW'(starveLimit));

   // Grants are blocked while in reset or during a clear cycle.
   always_comb begin
      gnt_wb  = 1'b0;
      gnt_fl  = 1'b0;
      gnt_ext = 1'b0;
      if (nrst && !clear_i) begin
         if (ext_valid_i && promoted) gnt_ext = 1'b1;
         else if (wb_valid_i)         gnt_wb  = 1'b1;
         else if (fl_valid_i)         gnt_fl  = 1'b1;
         else if (ext_valid_i)        gnt_ext = 1'b1;
      end
   end

   assign wb_ready_o  = gnt_wb;
   assign fl_ready_o  = gnt_fl;
   assign ext_ready_o = gnt_ext;

   always_comb begin
      mem_en_o    = 1'b0;
      mem_wen_o   = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      tag_d       = TAG_NONE;
      if (gnt_wb) begin
         mem_en_o    = 1'b1;
         mem_wen_o   = 1'b1;
         mem_addr_o  = wb_addr_i;
         mem_wdata_o = wb_data_i;
      end else if (gnt_fl) begin
         mem_en_o    = 1'b1;
         mem_addr_o  = fl_addr_i;
         tag_d       = TAG_FL;
      end else if (gnt_ext) begin
         mem_en_o    = 1'b1;
         mem_wen_o   = ext_wen_i;
         mem_addr_o  = ext_addr_i;
         mem_wdata_o = ext_wen_i ? ext_wdata_i : '0;
         tag_d       = ext_wen_i ? TAG_NONE : TAG_EXT;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         starve_cnt <= '0;
         tag_q      <= TAG_NONE;
      end else if (clear_i) begin
         starve_cnt <= '0;
         tag_q      <= TAG_NONE;
      end else begin
         tag_q <= tag_d;
         if (!ext_valid_i || gnt_ext) starve_cnt <= '0;
         else                         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // clear_i also squashes the response already in flight this cycle.
   assign fl_rsp_valid_o  = (tag_q == TAG_FL)  && !clear_i;
   assign ext_rsp_valid_o = (tag_q == TAG_EXT) && !clear_i;
   assign rsp_data_o      = (fl_rsp_valid_o || ext_rsp_valid_o) ? mem_rdata_i : '0;

`ifdef QRACC_ACTBUF_ARB_STATS_EN
   logic        conflict;
   logic [31:0] stat_q;

   assign conflict = (wb_valid_i && fl_valid_i) || (wb_valid_i && ext_valid_i) ||
                     (fl_valid_i && ext_valid_i);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)                     stat_q <= '0;
      else if (clear_i)              stat_q <= '0;
      else if (conflict && stat_q != '1) stat_q <= stat_q + 1'b1;
   end

   assign stat_conflict_o = stat_q;
`else
   assign stat_conflict_o = '0;
`endif

endmodule
